// File: rtl/mem_access_unit.sv
// Memory-stage controller: single-outstanding req/ack loads and stores, registered write-back fields.
// Optional macro MEM_MISALIGN_CHECK_EN: misaligned half/word accesses skip the bus and raise misalign_o.
module mem_access_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_mem2reg,
    input  logic              in_reg_write,
    input  logic [4:0]        in_rd,
    output logic              stall_o,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              wb_valid,
    output logic              wb_mem2reg,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic              misalign_o
);

    // Bus handshake: bus_req rises the cycle after an aligned mem op is accepted and,
    // together with every other bus_* output, stays stable until the one-cycle bus_ack.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state, state_nx;
    logic              mem_op, misaligned, start;
    logic              size_byte, size_half;
    logic [3:0]        st_strb;
    logic [DATA_W-1:0] st_data;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_lane;
    logic              lat_mem2reg, lat_reg_write;
    logic [4:0]        lat_rd;
    logic [DATA_W-1:0] lat_alu;
    logic [DATA_W-1:0] byte_shift, half_shift, ld_data;

    assign mem_op    = in_mem_read | in_mem_write;
    assign size_byte = (in_funct3[1:0] == 2'b00);
    assign size_half = (in_funct3[1:0] == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = mem_op && ((size_half && in_addr[0]) ||
                                   (!size_byte && !size_half && (in_addr[1:0] != 2'b00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_o <= 1'b0;
        else        misalign_o <= (state == IDLE) && in_valid && misaligned;
    end
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall_o  = 1'b0;
        start    = 1'b0;
        case (state)
            IDLE: begin
                start   = in_valid && mem_op && !misaligned;
                stall_o = start;
                if (start) state_nx = BUSY;
            end
            BUSY: begin
                stall_o = !bus_ack;
                if (bus_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reserved size encodings fall through to the word case.
    always_comb begin
        st_strb = 4'b1111;
        st_data = in_wdata;
        if (size_byte) begin
            st_strb = 4'b0001 << in_addr[1:0];
            st_data = {(DATA_W/8){in_wdata[7:0]}};
        end else if (size_half) begin
            st_strb = 4'b0011 << {in_addr[1], 1'b0};
            st_data = {(DATA_W/16){in_wdata[15:0]}};
        end
    end

    always_comb begin
        byte_shift = bus_rdata >> {lat_lane, 3'b000};
        half_shift = bus_rdata >> {lat_lane[1], 4'b0000};
        ld_data    = bus_rdata;
        if (lat_funct3[1:0] == 2'b00)
            ld_data = {{(DATA_W-8){byte_shift[7] & ~lat_funct3[2]}}, byte_shift[7:0]};
        else if (lat_funct3[1:0] == 2'b01)
            ld_data = {{(DATA_W-16){half_shift[15] & ~lat_funct3[2]}}, half_shift[15:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wstrb     <= 4'b0000;
            bus_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_mem2reg    <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= 5'd0;
            wb_mem_data   <= '0;
            wb_alu_result <= '0;
            lat_funct3    <= 3'b000;
            lat_lane      <= 2'b00;
            lat_mem2reg   <= 1'b0;
            lat_reg_write <= 1'b0;
            lat_rd        <= 5'd0;
            lat_alu       <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (start) begin
                bus_req       <= 1'b1;
                bus_we        <= in_mem_write;
                bus_addr      <= {in_addr[DATA_W-1:2], 2'b00};
                bus_wstrb     <= in_mem_write ? st_strb : 4'b0000;
                bus_wdata     <= in_mem_write ? st_data : '0;
                lat_funct3    <= in_funct3;
                lat_lane      <= in_addr[1:0];
                lat_mem2reg   <= in_mem2reg;
                lat_reg_write <= in_reg_write;
                lat_rd        <= in_rd;
                lat_alu       <= in_alu_result;
            end else if (state == BUSY) begin
                if (bus_ack) begin
                    bus_req       <= 1'b0;
                    wb_valid      <= 1'b1;
                    wb_mem2reg    <= lat_mem2reg;
                    wb_reg_write  <= lat_reg_write;
                    wb_rd         <= lat_rd;
                    wb_alu_result <= lat_alu;
                    wb_mem_data   <= bus_we ? '0 : ld_data;
                end
            end else begin
                wb_valid      <= in_valid;
                wb_mem2reg    <= in_mem2reg;
                wb_reg_write  <= in_reg_write && !misaligned;
                wb_rd         <= in_rd;
                wb_alu_result <= in_alu_result;
                wb_mem_data   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, pipelining around ALU ops, misalign and reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_mem_read, in_mem_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata, in_alu_result;
    logic        in_mem2reg, in_reg_write;
    logic [4:0]  in_rd;
    logic        stall_o, bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        wb_valid, wb_mem2reg, wb_reg_write, misalign_o;
    logic [4:0]  wb_rd;
    logic [31:0] wb_mem_data, wb_alu_result;

    int vectors = 0;
    int miscompares = 0;

    // Observations gathered by run_mem for the calling test to compare.
    int          obs_stall_cycles, obs_wbv_pulses;
    logic        obs_req_seen, obs_req_we, obs_stall_at_ack, obs_req_after, obs_hold_ok;
    logic [31:0] obs_req_addr, obs_req_wdata, obs_mem_data;
    logic [3:0]  obs_req_strb;
    logic        obs_mem2reg, obs_reg_write;
    logic [4:0]  obs_rd;

    mem_access_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu_result(in_alu_result), .in_mem2reg(in_mem2reg), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .stall_o(stall_o),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_mem2reg(wb_mem2reg), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_funct3 = 3'b000;
        in_addr = 32'h0; in_wdata = 32'h0; in_alu_result = 32'h0;
        in_mem2reg = 1'b0; in_reg_write = 1'b0; in_rd = 5'd0;
    endtask

    task automatic present(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] alu, input logic m2r, input logic rw,
                           input logic [4:0] rd);
        in_valid = 1'b1; in_mem_read = rd_op; in_mem_write = wr_op; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_alu_result = alu;
        in_mem2reg = m2r; in_reg_write = rw; in_rd = rd;
    endtask

    // Presents one mem op at a cycle start, acks it k cycles after presentation.
    task automatic run_mem(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int k);
        present(rd_op, wr_op, f3, addr, wdata, 32'h0, rd_op, rd_op, 5'd7);
        #1;
        obs_stall_cycles = int'(stall_o);
        obs_wbv_pulses = 0;
        obs_hold_ok = 1'b1;
        step();
        #1;
        obs_req_seen = bus_req; obs_req_we = bus_we; obs_req_addr = bus_addr;
        obs_req_strb = bus_wstrb; obs_req_wdata = bus_wdata;
        for (int c = 1; c < k; c++) begin
            obs_stall_cycles += int'(stall_o);
            obs_wbv_pulses += int'(wb_valid);
            step();
            #1;
        end
        if (bus_req !== 1'b1 || bus_addr !== obs_req_addr || bus_wdata !== obs_req_wdata ||
            bus_wstrb !== obs_req_strb || bus_we !== obs_req_we) obs_hold_ok = 1'b0;
        bus_ack = 1'b1; bus_rdata = rdata;
        #1;
        obs_stall_at_ack = stall_o;
        obs_wbv_pulses += int'(wb_valid);
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        set_idle();
        #1;
        obs_wbv_pulses += int'(wb_valid);
        obs_mem_data = wb_mem_data; obs_mem2reg = wb_mem2reg;
        obs_reg_write = wb_reg_write; obs_rd = wb_rd; obs_req_after = bus_req;
        step();
        #1;
        obs_wbv_pulses += int'(wb_valid);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        set_idle();
        repeat (2) @(posedge clk);
        #2;
        vectors++; if ({bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, wb_valid, wb_mem2reg, wb_reg_write, wb_rd, wb_mem_data, wb_alu_result, misalign_o} !== '0) begin miscompares++; $display("FAIL reset_outputs: got req=%b we=%b addr=%h wb_valid=%b wb_mem_data=%h expected all zero", bus_req, bus_we, bus_addr, wb_valid, wb_mem_data); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        #2 rst_n = 1'b1;
        step();
        // Stray ack in IDLE alongside an ALU op must not start anything.
        present(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_0ABC, 1'b0, 1'b1, 5'd3);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL idle_ack_stall: got %b expected 0", stall_o); end
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0; set_idle();
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL idle_ack_req: got %b expected 0", bus_req); end
        vectors++; if (wb_valid !== 1'b1 || wb_alu_result !== 32'h0000_0ABC || wb_rd !== 5'd3 || wb_mem_data !== 32'h0) begin miscompares++; $display("FAIL idle_ack_wb: got valid=%b alu=%h rd=%0d mem=%h expected 1/00000abc/3/00000000", wb_valid, wb_alu_result, wb_rd, wb_mem_data); end
    endtask

    task automatic test_lw();
        step();
        run_mem(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3);
        vectors++; if (obs_stall_cycles != 3) begin miscompares++; $display("FAIL lw_stall_cycles: got %0d expected 3", obs_stall_cycles); end
        vectors++; if (obs_stall_at_ack !== 1'b0) begin miscompares++; $display("FAIL lw_stall_at_ack: got %b expected 0", obs_stall_at_ack); end
        vectors++; if (obs_req_seen !== 1'b1 || obs_req_addr !== 32'h0000_0104 || obs_req_we !== 1'b0 || obs_req_strb !== 4'b0000) begin miscompares++; $display("FAIL lw_bus: got req=%b addr=%h we=%b strb=%b expected 1/00000104/0/0000", obs_req_seen, obs_req_addr, obs_req_we, obs_req_strb); end
        vectors++; if (obs_hold_ok !== 1'b1) begin miscompares++; $display("FAIL lw_bus_hold: got %b expected 1", obs_hold_ok); end
        vectors++; if (obs_mem_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_data: got %h expected deadbeef", obs_mem_data); end
        vectors++; if (obs_mem2reg !== 1'b1 || obs_reg_write !== 1'b1 || obs_rd !== 5'd7) begin miscompares++; $display("FAIL lw_wb_ctrl: got m2r=%b rw=%b rd=%0d expected 1/1/7", obs_mem2reg, obs_reg_write, obs_rd); end
        vectors++; if (obs_wbv_pulses != 1) begin miscompares++; $display("FAIL lw_wb_pulses: got %0d expected 1", obs_wbv_pulses); end
        vectors++; if (obs_req_after !== 1'b0) begin miscompares++; $display("FAIL lw_req_drop: got %b expected 0", obs_req_after); end
    endtask

    task automatic test_sub_word_loads();
        logic [31:0] addr_t [6];
        logic [2:0]  f3_t   [6];
        logic [31:0] exp_t  [6];
        addr_t[0] = 32'h103; f3_t[0] = 3'b000; exp_t[0] = 32'hFFFF_FF80;
        addr_t[1] = 32'h103; f3_t[1] = 3'b100; exp_t[1] = 32'h0000_0080;
        addr_t[2] = 32'h102; f3_t[2] = 3'b001; exp_t[2] = 32'hFFFF_80FF;
        addr_t[3] = 32'h102; f3_t[3] = 3'b101; exp_t[3] = 32'h0000_80FF;
        addr_t[4] = 32'h100; f3_t[4] = 3'b000; exp_t[4] = 32'h0000_0001;
        addr_t[5] = 32'h100; f3_t[5] = 3'b001; exp_t[5] = 32'h0000_7F01;
        for (int i = 0; i < 6; i++) begin
            step();
            run_mem(1'b1, 1'b0, f3_t[i], addr_t[i], 32'h0, 32'h80FF_7F01, 1);
            vectors++; if (obs_mem_data !== exp_t[i]) begin miscompares++; $display("FAIL subword_load_%0d: got %h expected %h", i, obs_mem_data, exp_t[i]); end
            vectors++; if (obs_req_addr !== 32'h100 || obs_req_strb !== 4'b0000) begin miscompares++; $display("FAIL subword_bus_%0d: got addr=%h strb=%b expected 00000100/0000", i, obs_req_addr, obs_req_strb); end
        end
    endtask

    task automatic test_stores();
        step();
        run_mem(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 32'h0, 2);
        vectors++; if (obs_req_addr !== 32'h200 || obs_req_strb !== 4'b0010 || obs_req_wdata !== 32'hA5A5_A5A5 || obs_req_we !== 1'b1) begin miscompares++; $display("FAIL sb_bus: got addr=%h strb=%b wdata=%h we=%b expected 00000200/0010/a5a5a5a5/1", obs_req_addr, obs_req_strb, obs_req_wdata, obs_req_we); end
        vectors++; if (obs_stall_cycles != 2 || obs_mem_data !== 32'h0 || obs_wbv_pulses != 1) begin miscompares++; $display("FAIL sb_wb: got stall=%0d mem=%h pulses=%0d expected 2/00000000/1", obs_stall_cycles, obs_mem_data, obs_wbv_pulses); end
        step();
        run_mem(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 1);
        vectors++; if (obs_req_addr !== 32'h200 || obs_req_strb !== 4'b1100 || obs_req_wdata !== 32'hBEEF_BEEF) begin miscompares++; $display("FAIL sh_bus: got addr=%h strb=%b wdata=%h expected 00000200/1100/beefbeef", obs_req_addr, obs_req_strb, obs_req_wdata); end
        step();
        run_mem(1'b0, 1'b1, 3'b111, 32'h0000_0208, 32'h0102_0304, 32'h0, 1);
        vectors++; if (obs_req_strb !== 4'b1111 || obs_req_wdata !== 32'h0102_0304) begin miscompares++; $display("FAIL reserved_store: got strb=%b wdata=%h expected 1111/01020304", obs_req_strb, obs_req_wdata); end
    endtask

    task automatic test_alu_sw_alternate();
        step();
        present(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0011, 1'b0, 1'b1, 5'd1);
        #1;
        vectors++; if (stall_o !== 1'b0 || bus_req !== 1'b0) begin miscompares++; $display("FAIL alt_alu1_issue: got stall=%b req=%b expected 0/0", stall_o, bus_req); end
        step();
        present(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if (wb_valid !== 1'b1 || wb_alu_result !== 32'h11 || wb_mem_data !== 32'h0 || wb_rd !== 5'd1) begin miscompares++; $display("FAIL alt_alu1_wb: got valid=%b alu=%h mem=%h rd=%0d expected 1/00000011/00000000/1", wb_valid, wb_alu_result, wb_mem_data, wb_rd); end
        vectors++; if (bus_req !== 1'b0 || stall_o !== 1'b1) begin miscompares++; $display("FAIL alt_sw1_present: got req=%b stall=%b expected 0/1", bus_req, stall_o); end
        step();
        bus_ack = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h300 || bus_wstrb !== 4'b1111 || bus_wdata !== 32'h1234_5678 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL alt_sw1_bus: got req=%b addr=%h strb=%b wdata=%h wbv=%b expected 1/00000300/1111/12345678/0", bus_req, bus_addr, bus_wstrb, bus_wdata, wb_valid); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL alt_sw1_ack_stall: got %b expected 0", stall_o); end
        step();
        bus_ack = 1'b0;
        present(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0022, 1'b0, 1'b1, 5'd2);
        #1;
        vectors++; if (wb_valid !== 1'b1 || wb_mem_data !== 32'h0 || bus_req !== 1'b0 || stall_o !== 1'b0) begin miscompares++; $display("FAIL alt_sw1_done: got wbv=%b mem=%h req=%b stall=%b expected 1/00000000/0/0", wb_valid, wb_mem_data, bus_req, stall_o); end
        step();
        present(1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 5'd0);
        #1;
        vectors++; if (wb_valid !== 1'b1 || wb_alu_result !== 32'h22 || bus_req !== 1'b0) begin miscompares++; $display("FAIL alt_alu2_wb: got wbv=%b alu=%h req=%b expected 1/00000022/0", wb_valid, wb_alu_result, bus_req); end
        step();
        bus_ack = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h304 || bus_wdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL alt_sw2_bus: got req=%b addr=%h wdata=%h expected 1/00000304/cafef00d", bus_req, bus_addr, bus_wdata); end
        step();
        bus_ack = 1'b0; set_idle();
        #1;
        vectors++; if (wb_valid !== 1'b1 || bus_req !== 1'b0) begin miscompares++; $display("FAIL alt_sw2_done: got wbv=%b req=%b expected 1/0", wb_valid, bus_req); end
    endtask

    task automatic test_back_to_back();
        step();
        present(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0000_1111, 32'h0, 1'b0, 1'b0, 5'd0);
        step();
        bus_ack = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin miscompares++; $display("FAIL b2b_first_req: got req=%b addr=%h expected 1/00000400", bus_req, bus_addr); end
        step();
        bus_ack = 1'b0;
        present(1'b1, 1'b0, 3'b010, 32'h0000_0408, 32'h0, 32'h0, 1'b1, 1'b1, 5'd9);
        #1;
        vectors++; if (bus_req !== 1'b0 || wb_valid !== 1'b1 || stall_o !== 1'b1) begin miscompares++; $display("FAIL b2b_gap: got req=%b wbv=%b stall=%b expected 0/1/1", bus_req, wb_valid, stall_o); end
        step();
        bus_ack = 1'b1; bus_rdata = 32'h0000_55AA;
        #1;
        vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h408 || bus_we !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_second_req: got req=%b addr=%h we=%b wbv=%b expected 1/00000408/0/0", bus_req, bus_addr, bus_we, wb_valid); end
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0; set_idle();
        #1;
        vectors++; if (wb_valid !== 1'b1 || wb_mem_data !== 32'h0000_55AA || wb_rd !== 5'd9 || bus_req !== 1'b0) begin miscompares++; $display("FAIL b2b_second_wb: got wbv=%b mem=%h rd=%0d req=%b expected 1/000055aa/9/0", wb_valid, wb_mem_data, wb_rd, bus_req); end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
        step();
        present(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 1'b1, 5'd4);
        #1;
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL misalign_stall: got %b expected 0", stall_o); end
        step();
        set_idle();
        #1;
        vectors++; if (wb_valid !== 1'b1 || misalign_o !== 1'b1 || wb_reg_write !== 1'b0 || bus_req !== 1'b0) begin miscompares++; $display("FAIL misalign_flag: got wbv=%b mis=%b rw=%b req=%b expected 1/1/0/0", wb_valid, misalign_o, wb_reg_write, bus_req); end
        step();
        vectors++; if (misalign_o !== 1'b0 || wb_valid !== 1'b0 || bus_req !== 1'b0) begin miscompares++; $display("FAIL misalign_pulse: got mis=%b wbv=%b req=%b expected 0/0/0", misalign_o, wb_valid, bus_req); end
`else
        step();
        run_mem(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1122_3344, 1);
        vectors++; if (obs_req_seen !== 1'b1 || obs_req_addr !== 32'h100 || obs_mem_data !== 32'h1122_3344) begin miscompares++; $display("FAIL unaligned_lw: got req=%b addr=%h data=%h expected 1/00000100/11223344", obs_req_seen, obs_req_addr, obs_mem_data); end
        vectors++; if (misalign_o !== 1'b0 || obs_reg_write !== 1'b1) begin miscompares++; $display("FAIL unaligned_flags: got mis=%b rw=%b expected 0/1", misalign_o, obs_reg_write); end
`endif
    endtask

    task automatic test_reset_busy();
        step();
        present(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h0, 1'b1, 1'b1, 5'd6);
        step();
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL rstbusy_req: got %b expected 1", bus_req); end
        #2;
        rst_n = 1'b0; set_idle();
        #1;
        vectors++; if (bus_req !== 1'b0 || stall_o !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL rstbusy_async: got req=%b stall=%b wbv=%b expected 0/0/0", bus_req, stall_o, wb_valid); end
        step();
        #3 rst_n = 1'b1;
        step();
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rstbusy_stray_stall: got %b expected 0", stall_o); end
        step();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        vectors++; if (wb_valid !== 1'b0 || bus_req !== 1'b0 || wb_mem_data !== 32'h0) begin miscompares++; $display("FAIL rstbusy_stray_wb: got wbv=%b req=%b mem=%h expected 0/0/00000000", wb_valid, bus_req, wb_mem_data); end
        step();
        run_mem(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 2);
        vectors++; if (obs_mem_data !== 32'h0BAD_F00D || obs_req_addr !== 32'h600 || obs_wbv_pulses != 1) begin miscompares++; $display("FAIL rstbusy_recover: got data=%h addr=%h pulses=%0d expected 0badf00d/00000600/1", obs_mem_data, obs_req_addr, obs_wbv_pulses); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_alu_sw_alternate();
        test_back_to_back();
        test_misalign();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
